// File: rtl/timer_pkg.sv
// Shared definitions for the timer channel: state encoding, the enable/complete
// handshake seen by the timer FSM, and small sizing helpers.
package timer_pkg;

  // Counter state; the encoding is shared with the FSM side, so it is fixed.
  typedef logic [1:0] timer_state_t;

  localparam timer_state_t StIdle    = 2'd0;
  localparam timer_state_t StRun     = 2'd1;
  localparam timer_state_t StHold    = 2'd2;
  localparam timer_state_t StExpired = 2'd3;

  // Handshake wires presented to the timer FSM ({enable, complete}).
  typedef struct packed {
    logic enable;
    logic complete;
  } timer_hsk_t;

  localparam timer_hsk_t HskOff    = 2'b00;
  localparam timer_hsk_t HskActive = 2'b10;
  localparam timer_hsk_t HskDone   = 2'b11;

  // Handshake value for a given counter state.
  function automatic timer_hsk_t state_hsk(timer_state_t st);
    timer_hsk_t hsk;
    hsk = HskOff;
    case (st)
      StRun:     hsk = HskActive;
      StExpired: hsk = HskDone;
      default:   hsk = HskOff;
    endcase
    return hsk;
  endfunction

  // Prescaler counter width; a single bit even when PRESCALE is 1.
  function automatic int unsigned prescale_width(int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Software-control and FSM-handshake bundle of one timer channel.
interface timer_counter_if #(
  parameter int unsigned WIDTH = 16
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             trigger;
  logic             enable;
  logic             complete;
  logic [WIDTH-1:0] count;
  logic             busy;

  // Register interface / timer FSM side.
  modport master (
    output load, load_value, start, pause, trigger,
    input  enable, complete, count, busy
  );

  // Counter side.
  modport slave (
    input  load, load_value, start, pause, trigger,
    output enable, complete, count, busy
  );

endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for the timer channel: divides the clock by PRESCALE while run is
// high and flags the last phase as a count tick.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter  int unsigned PRESCALE = 4,
  localparam int unsigned PhaseW   = prescale_width(PRESCALE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              clear,
  output logic              tick,
  output logic [PhaseW-1:0] phase
);

  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(PRESCALE - 1);

  logic [PhaseW-1:0] phase_q, phase_d;
  logic              at_last;

  assign at_last = (phase_q == PhaseLast);

  // Next phase: clear wins, otherwise advance and wrap while running, else hold.
  always_comb begin
    phase_d = phase_q;
    if (clear) begin
      phase_d = '0;
    end else if (run) begin
      phase_d = at_last ? '0 : phase_q + PhaseW'(1);
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign tick  = run & at_last;
  assign phase = phase_q;

endmodule

// File: rtl/timer_counter.sv
// Programmable countdown engine for one timer channel. Drives enable/complete
// towards the timer FSM and takes its DONE output (trigger) as expiry ack.
module timer_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned PRESCALE    = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  localparam int unsigned PhaseW = prescale_width(PRESCALE);

  timer_state_t      state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic [WIDTH-1:0]  reload_q, reload_d;

  logic              pre_run;
  logic              pre_clear;
  logic              tick;
  logic [PhaseW-1:0] phase;
  logic              pause_eff;
  logic              count_nz;
  logic              reload_nz;
  timer_hsk_t        hsk;

  // start outranks pause, and load outranks both.
  assign pause_eff = bus.pause & ~bus.start;
  assign count_nz  = (count_q != '0);
  assign reload_nz = (reload_q != '0);

  // Prescaler advances only in RUN cycles that are not being paused or loaded,
  // so a pause coinciding with a tick swallows that decrement.
  assign pre_run = (state_q == StRun) & ~bus.load & ~pause_eff;

  // Fresh prescale period on load, on start from IDLE and on auto-reload.
  always_comb begin
    pre_clear = 1'b0;
    if (bus.load) begin
      pre_clear = 1'b1;
    end else if (state_q == StIdle && bus.start && count_nz) begin
      pre_clear = 1'b1;
    end else if (state_q == StExpired && bus.trigger && AUTO_RELOAD && reload_nz) begin
      pre_clear = 1'b1;
    end
  end

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (pre_run),
    .clear (pre_clear),
    .tick  (tick),
    .phase (phase)
  );

  // Next state, count and reload value.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    if (bus.load) begin
      count_d  = bus.load_value;
      reload_d = bus.load_value;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && count_nz) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (pause_eff) begin
            state_d = StHold;
          end else if (tick && count_nz) begin
            count_d = count_q - WIDTH'(1);
            if (count_q == WIDTH'(1)) begin
              state_d = StExpired;
            end
          end
        end
        StHold: begin
          if (bus.start) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (bus.trigger) begin
            if (AUTO_RELOAD && reload_nz) begin
              count_d = reload_q;
              state_d = StRun;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, count and reload registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  // Outputs decode straight from registered state; no input-to-output paths.
  assign hsk          = state_hsk(state_q);
  assign bus.enable   = hsk.enable;
  assign bus.complete = hsk.complete;
  assign bus.busy     = (state_q == StRun) | (state_q == StHold);
  assign bus.count    = count_q;

  // A held counter must resume from exactly the prescaler phase it stopped at.
  a_hold_keeps_phase: assert property (@(posedge clk) disable iff (reset)
      (state_q == StHold && !bus.load) |=> $stable(phase));

  // RUN is only ever entered with something left to count.
  a_run_nonzero: assert property (@(posedge clk) disable iff (reset)
      (state_q == StRun) |-> count_nz);

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: three channels (PRESCALE 1, PRESCALE 4, auto-reload)
// driven by directed pulses; expected outputs per cycle sit in a scoreboard
// queue that a negedge monitor drains and compares.
module tb_timer_counter;

  logic clk;
  logic reset;
  int   cyc;

  timer_counter_if #(.WIDTH(16)) a_if ();
  timer_counter_if #(.WIDTH(16)) b_if ();
  timer_counter_if #(.WIDTH(16)) c_if ();

  timer_counter #(.WIDTH(16), .PRESCALE(1), .AUTO_RELOAD(1'b0)) u_p1 (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if)
  );

  timer_counter #(.WIDTH(16), .PRESCALE(4), .AUTO_RELOAD(1'b0)) u_p4 (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if)
  );

  timer_counter #(.WIDTH(16), .PRESCALE(1), .AUTO_RELOAD(1'b1)) u_ar (
    .clk   (clk),
    .reset (reset),
    .bus   (c_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = k throughout the period that follows rising edge k.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {enable, complete, busy, count}
  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [18:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic expect_at(input int c, input int d, input string nm, input logic en,
                           input logic cmp, input logic bsy, input logic [15:0] cnt);
    exp_t e;
    e.cyc  = c;
    e.dut  = d;
    e.name = nm;
    e.exp  = {en, cmp, bsy, cnt};
    sb.push_back(e);
  endtask

  function automatic logic [18:0] observed(input int d);
    logic [18:0] v;
    case (d)
      0:       v = {a_if.enable, a_if.complete, a_if.busy, a_if.count};
      1:       v = {b_if.enable, b_if.complete, b_if.busy, b_if.count};
      default: v = {c_if.enable, c_if.complete, c_if.busy, c_if.count};
    endcase
    return v;
  endfunction

  // Advance to cycle n, landing 1ns after its rising edge.
  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due in the current cycle.
  exp_t        mon_e;
  logic [18:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = observed(mon_e.dut);
      n_chk++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s dut%0d: checked in cycle %0d, due in cycle %0d", mon_e.name,
                 mon_e.dut, cyc, mon_e.cyc);
      end else if (mon_act !== mon_e.exp) begin
        $display("FAIL %s dut%0d cyc %0d: got en=%b cmp=%b busy=%b count=%0d, want en=%b cmp=%b busy=%b count=%0d",
                 mon_e.name, mon_e.dut, cyc, mon_act[18], mon_act[17], mon_act[16],
                 mon_act[15:0], mon_e.exp[18], mon_e.exp[17], mon_e.exp[16], mon_e.exp[15:0]);
      end else begin
        n_pass++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    a_if.load = 0; a_if.load_value = '0; a_if.start = 0; a_if.pause = 0; a_if.trigger = 0;
    b_if.load = 0; b_if.load_value = '0; b_if.start = 0; b_if.pause = 0; b_if.trigger = 0;
    c_if.load = 0; c_if.load_value = '0; c_if.start = 0; c_if.pause = 0; c_if.trigger = 0;

    // Expectations, in cycle order.
    for (int d = 0; d < 3; d++) expect_at(1, d, "reset_state", 0, 0, 0, 16'd0);
    // Channel A, PRESCALE = 1
    expect_at(4,  0, "a_load",       0, 0, 0, 16'd3);
    expect_at(5,  0, "a_run3",       1, 0, 1, 16'd3);
    expect_at(6,  0, "a_run2",       1, 0, 1, 16'd2);
    expect_at(7,  0, "a_run1",       1, 0, 1, 16'd1);
    expect_at(8,  0, "a_expired",    1, 1, 0, 16'd0);
    expect_at(9,  0, "a_expired_hi", 1, 1, 0, 16'd0);
    expect_at(10, 0, "a_ack_idle",   0, 0, 0, 16'd0);
    expect_at(12, 0, "a_start_zero", 0, 0, 0, 16'd0);
    expect_at(14, 0, "a_load_start", 0, 0, 0, 16'd6);
    expect_at(15, 0, "a_run6",       1, 0, 1, 16'd6);
    expect_at(16, 0, "a_reset_async", 0, 0, 0, 16'd0);
    expect_at(17, 0, "a_reset_held", 0, 0, 0, 16'd0);
    // Channel B, PRESCALE = 4
    expect_at(21, 1, "b_load",       0, 0, 0, 16'd2);
    expect_at(22, 1, "b_run",        1, 0, 1, 16'd2);
    expect_at(25, 1, "b_pre_tick",   1, 0, 1, 16'd2);
    expect_at(26, 1, "b_after_tick", 1, 0, 1, 16'd1);
    expect_at(28, 1, "b_before_pause", 1, 0, 1, 16'd1);
    for (int c = 29; c <= 38; c++) expect_at(c, 1, "b_hold", 0, 0, 1, 16'd1);
    expect_at(39, 1, "b_resume1",    1, 0, 1, 16'd1);
    expect_at(40, 1, "b_resume2",    1, 0, 1, 16'd1);
    expect_at(41, 1, "b_expired",    1, 1, 0, 16'd0);
    expect_at(42, 1, "b_ignore_start_pause", 1, 1, 0, 16'd0);
    expect_at(43, 1, "b_load_expired", 0, 0, 0, 16'd7);
    expect_at(44, 1, "b_run7",       1, 0, 1, 16'd7);
    expect_at(47, 1, "b_tick_cycle", 1, 0, 1, 16'd7);
    expect_at(48, 1, "b_pause_tick", 0, 0, 1, 16'd7);
    expect_at(49, 1, "b_resume_last_phase", 1, 0, 1, 16'd7);
    expect_at(50, 1, "b_resume_tick", 1, 0, 1, 16'd6);
    expect_at(51, 1, "b_trigger_ignored", 1, 0, 1, 16'd6);
    // Channel C, PRESCALE = 1, AUTO_RELOAD = 1
    expect_at(61, 2, "c_load",       0, 0, 0, 16'd2);
    expect_at(62, 2, "c_run2",       1, 0, 1, 16'd2);
    expect_at(63, 2, "c_run1",       1, 0, 1, 16'd1);
    expect_at(64, 2, "c_expired",    1, 1, 0, 16'd0);
    expect_at(65, 2, "c_expired_hi", 1, 1, 0, 16'd0);
    expect_at(66, 2, "c_reload2",    1, 0, 1, 16'd2);
    expect_at(67, 2, "c_reload1",    1, 0, 1, 16'd1);
    expect_at(68, 2, "c_expired2",   1, 1, 0, 16'd0);
    expect_at(69, 2, "c_expired2_hi", 1, 1, 0, 16'd0);
    expect_at(70, 2, "c_reload_again", 1, 0, 1, 16'd2);
    expect_at(71, 2, "c_load_zero",  0, 0, 0, 16'd0);

    go(2);
    reset = 1'b0;

    // Channel A: basic countdown, ack, start on zero, load+start, async reset.
    go(3);  a_if.load_value = 16'd3; a_if.load = 1;
    go(4);  a_if.load = 0; a_if.start = 1;
    go(5);  a_if.start = 0;
    go(9);  a_if.trigger = 1;
    go(10); a_if.trigger = 0;
    go(11); a_if.start = 1;
    go(12); a_if.start = 0;
    go(13); a_if.load_value = 16'd6; a_if.load = 1; a_if.start = 1;
    go(14); a_if.load = 0;
    go(15); a_if.start = 0;
    go(16); reset = 1'b1;
    go(17); reset = 1'b0;

    // Channel B: pause/resume, ignored inputs in EXPIRED, pause on a tick.
    go(20); b_if.load_value = 16'd2; b_if.load = 1;
    go(21); b_if.load = 0; b_if.start = 1;
    go(22); b_if.start = 0;
    go(28); b_if.pause = 1;
    go(29); b_if.pause = 0;
    go(38); b_if.start = 1;
    go(39); b_if.start = 0;
    go(41); b_if.pause = 1; b_if.start = 1;
    go(42); b_if.pause = 0; b_if.start = 0; b_if.load_value = 16'd7; b_if.load = 1;
    go(43); b_if.load = 0; b_if.start = 1;
    go(44); b_if.start = 0;
    go(47); b_if.pause = 1;
    go(48); b_if.pause = 0; b_if.start = 1;
    go(49); b_if.start = 0;
    go(50); b_if.trigger = 1;
    go(51); b_if.trigger = 0;

    // Channel C: auto-reload with FSM acknowledging one cycle after complete.
    go(60); c_if.load_value = 16'd2; c_if.load = 1;
    go(61); c_if.load = 0; c_if.start = 1;
    go(62); c_if.start = 0;
    go(65); c_if.trigger = 1;
    go(66); c_if.trigger = 0;
    go(69); c_if.trigger = 1;
    go(70); c_if.trigger = 0; c_if.load_value = 16'd0; c_if.load = 1;
    go(71); c_if.load = 0;

    go(72);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_chk++;
      $display("FAIL %s dut%0d: never checked, due in cycle %0d", mon_e.name, mon_e.dut,
               mon_e.cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Programmable countdown engine that drives the `enable`/`complete` inputs of the timer control FSM and consumes its `trigger` (DONE) output as the expiry acknowledge. Software-side controls (`load`, `start`, `pause`) set and steer a prescaled down-counter. The block reports running/expired status on the FSM-facing wires. It sits between the register interface and the timer FSM, one instance per timer channel.

## Interface
- `WIDTH`, 16, count register width; legal range ≥ 2.
- `PRESCALE`, 4, clock cycles per count decrement; legal range ≥ 1.
- `AUTO_RELOAD`, 0, 1 = restart from the reload value after acknowledge; 0 = return to idle.

- `clk` input 1 — single clock, rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state.
- `load` input 1 — pulse; copy `load_value` into count and reload registers.
- `load_value` input WIDTH — initial/reload count.
- `start` input 1 — pulse; start from idle, or resume from hold.
- `pause` input 1 — pulse; freeze counting.
- `trigger` input 1 — expiry acknowledge from the timer FSM (DONE state).
- `enable` output 1 — counter active, to FSM `enable`.
- `complete` output 1 — count expired, to FSM `complete`.
- `count` output WIDTH — current count value.
- `busy` output 1 — high in RUN or HOLD.

## Operation
- States: IDLE, RUN, HOLD, EXPIRED. All outputs are registered or decoded from state; no input-to-output combinational paths.
- Reset values: state = IDLE; `count` = 0; reload register = 0; prescaler = 0; `enable` = 0; `complete` = 0; `busy` = 0.
- Input priority: `load` > `start` > `pause`.
- **`load` (any state):**
  - count ← `load_value`; reload register ← `load_value`; prescaler ← 0.
  - State → IDLE. `complete` drops, including when loaded from EXPIRED.
- **IDLE:**
  - Outputs: `enable` = 0, `complete` = 0.
  - `start` with count ≠ 0 → RUN; prescaler ← 0.
  - `start` with count = 0 is ignored.
- **RUN:**
  - Outputs: `enable` = 1, `complete` = 0.
  - Prescaler increments each cycle and wraps at PRESCALE−1.
  - A tick is the cycle in which prescaler = PRESCALE−1. On a tick, count decrements.
  - A tick with count = 1 → count = 0 and state → EXPIRED.
  - `pause` → HOLD; prescaler and count are kept. If `pause` and a tick coincide, the pause wins and no decrement occurs.
- **HOLD:**
  - Outputs: `enable` = 0, `complete` = 0.
  - `start` → RUN; prescaler resumes from its held value.
- **EXPIRED:**
  - Outputs: `enable` = 1, `complete` = 1, held until acknowledged.
  - On `trigger` = 1:
    - AUTO_RELOAD = 1 and reload ≠ 0: count ← reload, prescaler ← 0, state → RUN.
    - Otherwise: state → IDLE, count stays 0.
  - `pause` and `start` are ignored.
- Arithmetic:
  - Count never decrements below 0; no wrap-around.
  - Prescaler width is max(1, $clog2(PRESCALE)).
  - PRESCALE = 1 means a tick every RUN cycle.
- `trigger` outside EXPIRED is ignored.
- Asynchronous reset during any state returns to reset values immediately; no pending pulse survives.

## Timing
- `start` sampled at edge n → RUN visible, `enable` = 1, in cycle n+1.
- Expiry latency: with count N loaded, EXPIRED and `complete` = 1 are visible in cycle n+1+N·PRESCALE.
- The FSM registers DONE one cycle after EXPIRED is entered, so `trigger` arrives at the earliest one cycle later. Minimum `complete` high time is 2 cycles.
- `trigger` sampled at edge m → `complete` = 0 in cycle m+1.
- With AUTO_RELOAD = 1, `enable` stays 1 continuously across the reload.
- `load` sampled at edge k → new `count` visible in cycle k+1.

## Structure
- Shared package `timer_pkg` holds:
  - the state enumeration (2-bit, IDLE = 0, RUN = 1, HOLD = 2, EXPIRED = 3);
  - the FSM-handshake encoding constants, shared with the timer FSM.
- One sub-module, `timer_prescaler`:
  - ports: clk, reset, run, clear → tick, phase;
  - holds the prescaler counter and tick generation.
- The top level holds the state register, count/reload registers and output decode.

## Test plan
- Reset mid-RUN (count = 5) → all outputs 0 and `count` = 0 while `reset` is high, before the next clock edge.
- PRESCALE = 1, `load_value` = 3, `start` at cycle 0 → `count` 3, 2, 1 in cycles 1–3; `complete` = 1 in cycle 4; `trigger` at cycle 5 → IDLE with `enable` = 0 in cycle 6.
- PRESCALE = 4, `load_value` = 2, `pause` after 6 RUN cycles, hold 10 cycles, then `start` → `count` frozen at 1 during HOLD; expiry exactly 2 RUN cycles after resume.
- AUTO_RELOAD = 1, `load_value` = 2, PRESCALE = 1 → `complete` pulses recur every 4 cycles (2 counting + 2 handshake) with `enable` never dropping.
- `start` with count = 0 → stays IDLE; `load` while EXPIRED → `complete` = 0 next cycle and `count` = `load_value`.
- `pause` and a tick in the same cycle → no decrement; `load` + `start` together → IDLE with the new count.
